debounce_multi: RTL
===================

Name: debounce_multi

Overview:
Parametrised N-channel push-button conditioner for the timer front panel. It supersedes the fixed three-button edge detector, which used two flops on a slow second clock. Each channel gets:
- a synchroniser;
- a counter-based stability filter on a shared sample tick derived from the single system clock;
- press and release strobes;
- optional hold-to-auto-repeat for the minute and second buttons.
Outputs feed the timer control FSM directly.

Parameters:
N_CH, 3, number of button channels (>=1)
SAMPLE_DIV, 100000, clk cycles per sample tick (>=1; 1 = tick every cycle)
STABLE_CNT, 4, consecutive differing samples needed to accept a new level (>=1)
REPEAT_EN, 1, 0 removes all repeat logic
REPEAT_DLY, 50, sample ticks from accepted press to first repeat (>=1)
REPEAT_RATE, 10, sample ticks between subsequent repeats (>=1)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  reset, asynchronous, active-high
btn_in  input  N_CH  raw asynchronous button levels, 1 = pressed
repeat_mask  input  N_CH  per-channel auto-repeat enable (ANDed with REPEAT_EN)
level_out  output  N_CH  debounced level
press_pulse  output  N_CH  one-clk strobe on accepted press and on each repeat
release_pulse  output  N_CH  one-clk strobe on accepted release
sample_tick  output  1  prescaler strobe, one clk wide

Behaviour:
- Reset (async assert, sync release): prescaler, synchronisers, filter counters and repeat counters = 0; states = IDLE; every output = 0 immediately, with no clk edge required.
- Synchroniser: two flops per channel on clk, reset to 0.
- Prescaler:
  - counts 0..SAMPLE_DIV-1, then wraps to 0;
  - sample_tick = 1 in the cycle where count == SAMPLE_DIV-1.
- Filter, per channel, evaluated only on sample_tick:
  - sync != level_out: cnt++; on the tick where cnt would reach STABLE_CNT, level_out flips and cnt = 0;
  - sync == level_out: cnt = 0.
  - A glitch lasting fewer than STABLE_CNT consecutive ticks never changes level_out.
- Strobes:
  - press_pulse / release_pulse register on the same edge as the level_out flip (0->1 / 1->0);
  - each strobe is high for exactly one clk.
- Latency: stable btn_in change to strobe = 2 clk + (STABLE_CNT-1)*SAMPLE_DIV + 1..SAMPLE_DIV clk.
- Repeat FSM per channel (states IDLE, HOLD_WAIT, REPEATING; rep_cnt advances only on ticks):
  - IDLE -> HOLD_WAIT on accepted press when mask bit = 1; rep_cnt = 0.
  - HOLD_WAIT: rep_cnt++ per tick; at REPEAT_DLY: press_pulse, go to REPEATING, rep_cnt = 0.
  - REPEATING: at REPEAT_RATE: press_pulse, rep_cnt = 0.
  - Accepted release in any state: IDLE, release_pulse, no repeat on that tick (release wins).
  - Mask bit cleared while in HOLD_WAIT/REPEATING: IDLE at the next tick, no further repeats; level_out unaffected.
  - REPEAT_EN = 0: FSM absent; press strobes only on accepted press.
- Channels are fully independent. Simultaneous events on several channels produce strobes in the same cycle.
- Button held through reset: after release of rst, level_out = 0 and the held level is accepted as a new press after STABLE_CNT ticks, with press_pulse.
- Counter widths use $clog2(max+1). No counter may overflow at any legal parameter value.

Decomposition:
- debounce_pkg:
  - repeat state enum typedef (IDLE/HOLD_WAIT/REPEATING);
  - default parameter constants;
  - width helper function.
- Sub-module debounce_chan (synchroniser + filter + repeat FSM for one channel), instantiated N_CH times by generate.
- The prescaler stays in the top level and is shared by all channels.

Test Plan:
Bench parameters: SAMPLE_DIV=4, STABLE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2, N_CH=3.
1. Clean press: btn_in[0] 0->1, held 20 ticks, then 0 -> exactly one press_pulse[0] within 2+8+1..4 clk of the edge; level_out[0] high; exactly one release_pulse[0] after the same latency following release.
2. Bounce: btn_in[1] toggles every 5 clk for 60 clk, then held 1 -> no strobes or level change during toggling; exactly one press_pulse[1] 3 ticks into the stable hold.
3. Auto-repeat: repeat_mask[0]=1, btn_in[0] held 16 ticks past acceptance at tick T -> press_pulse[0] at T, T+5, T+7, T+9, T+11, T+13, T+15; release -> release_pulse only, no extra repeat.
4. Mask off: repeat_mask=0, same hold as test 3 -> single press_pulse[0] only. Mask cleared at T+6 in test 3 -> no pulses after T+5.
5. Concurrency: btn_in[0] and btn_in[2] rise in the same clk, btn_in[1]=0 -> press_pulse = 3'b101 in a single cycle; channel 1 silent.
6. Async reset mid-REPEATING, button still held -> all outputs 0 with no clk edge. After rst falls: press_pulse[0] exactly 3 ticks later; first repeat 5 ticks after that.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types, default parameter values and counter-width helper for the
// multi-channel push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } rep_state_e;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_SAMPLE_DIV  = 100000;
  localparam int DEF_STABLE_CNT  = 4;
  localparam int DEF_REPEAT_EN   = 1;
  localparam int DEF_REPEAT_DLY  = 50;
  localparam int DEF_REPEAT_RATE = 10;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, tick-driven stability filter,
// press/release strobes and optional hold-to-repeat state machine.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int REPEAT_EN   = DEF_REPEAT_EN,
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  input  logic mask,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int FW      = cnt_w(STABLE_CNT - 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = cnt_w(REP_MAX - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rise, fall;
  logic          repeat_fire;

  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    level_d   = level_q;
    flt_cnt_d = flt_cnt_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (flt_cnt_q == FW'(STABLE_CNT - 1)) begin
          level_d   = ~level_q;
          flt_cnt_d = '0;
          rise      = ~level_q;
          fall      = level_q;
        end else begin
          flt_cnt_d = flt_cnt_q + 1'b1;
        end
      end else begin
        flt_cnt_d = '0;
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rep
      rep_state_e    state_q, state_d;
      logic [RW-1:0] rep_cnt_q, rep_cnt_d;
      logic          fire;

      // Release outranks everything, then a fresh press, then a dropped mask.
      always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        fire      = 1'b0;
        if (tick) begin
          if (fall) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
          end else if (rise) begin
            state_d   = mask ? HOLD_WAIT : IDLE;
            rep_cnt_d = '0;
          end else if (!mask) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
          end else begin
            case (state_q)
              HOLD_WAIT: begin
                if (rep_cnt_q == RW'(REPEAT_DLY - 1)) begin
                  fire      = 1'b1;
                  state_d   = REPEATING;
                  rep_cnt_d = '0;
                end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
                end
              end
              REPEATING: begin
                if (rep_cnt_q == RW'(REPEAT_RATE - 1)) begin
                  fire      = 1'b1;
                  rep_cnt_d = '0;
                end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
                end
              end
              default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
              end
            endcase
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q   <= IDLE;
          rep_cnt_q <= '0;
        end else begin
          state_q   <= state_d;
          rep_cnt_q <= rep_cnt_d;
        end
      end

      assign repeat_fire = fire;
    end else begin : g_norep
      assign repeat_fire = 1'b0;
    end
  endgenerate

  assign press_d = rise | repeat_fire;
  assign rel_d   = fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      flt_cnt_q <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      flt_cnt_q <= flt_cnt_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel button conditioner: one shared sample-tick prescaler feeding an
// independent debounce/repeat channel per button.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int REPEAT_EN   = DEF_REPEAT_EN,
  parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_mask,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            sample_tick
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;

  // Gated by rst so the strobe is low during reset even when SAMPLE_DIV is 1.
  assign tick = !rst && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign sample_tick = tick;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      debounce_chan #(
        .STABLE_CNT (STABLE_CNT),
        .REPEAT_EN  (REPEAT_EN),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
      ) u_chan (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .btn  (btn_in[i]),
        .mask (repeat_mask[i]),
        .level(level_out[i]),
        .press(press_pulse[i]),
        .rel  (release_pulse[i])
      );
    end
  endgenerate

endmodule
